instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 40 ++++
 rtl/instruction_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: the instruction-memory request/response channel and the decode handshake.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding imem requester feeding a small circular decode buffer.
// Define IF_MISALIGN_CHECK_EN to turn misaligned PCs into fault entries instead of requests.
module instruction_fetch #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [31:0]         pc_address,
    output logic                pc_advance,
    input  logic                flush,
    instruction_fetch_if.master bus_io
);

    localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW:0]   DepthCnt = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e          state_q;
    logic [31:0]     tag_q;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     pc_mem_q    [FIFO_DEPTH];

    logic            outstanding;
    logic [CntW:0]   occupancy;
    logic            room;
    logic            slot_free;
    logic            req_ok;
    logic            data_push;
    logic            push;
    logic            pop;
    logic [31:0]     push_instr;
    logic [31:0]     push_pc;

    // A response arriving this cycle frees the slot, but still counts against buffer space.
    always_comb begin
        outstanding = (state_q != StIdle);
        occupancy   = {1'b0, count_q} + {{CntW{1'b0}}, outstanding};
        room        = (occupancy < DepthCnt);
        slot_free   = (state_q == StIdle) || ((state_q == StWait) && bus_io.imem_rvalid);
        req_ok      = !reset && !flush && slot_free && room;
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic fault_lock_q;
    logic misaligned;
    logic fault_push;
    logic fault_mem_q [FIFO_DEPTH];

    assign misaligned      = (pc_address[1:0] != 2'b00);
    assign bus_io.imem_req = req_ok && !misaligned && !fault_lock_q;
    // Faults only enter from IDLE so they never collide with a response push.
    assign fault_push      = req_ok && misaligned && !fault_lock_q && (state_q == StIdle);
    assign bus_io.if_fault = bus_io.if_valid && fault_mem_q[rd_ptr_q];

    always_ff @(posedge clk_in) begin
        if (reset || flush) begin
            fault_lock_q <= 1'b0;
        end else if (fault_push) begin
            fault_lock_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fault_mem_q[wr_ptr_q] <= fault_push;
        end
    end
`else
    logic fault_push;

    assign fault_push      = 1'b0;
    assign bus_io.imem_req = req_ok;
    assign bus_io.if_fault = 1'b0;
`endif

    assign bus_io.imem_addr = pc_address;
    assign pc_advance       = bus_io.imem_req && bus_io.imem_gnt;

    assign data_push  = (state_q == StWait) && bus_io.imem_rvalid && !flush;
    assign push       = data_push || fault_push;
    assign push_instr = fault_push ? 32'h0 : bus_io.imem_rdata;
    assign push_pc    = fault_push ? pc_address : tag_q;

    assign bus_io.if_valid = !reset && (count_q != '0);
    assign bus_io.if_instr = instr_mem_q[rd_ptr_q];
    assign bus_io.if_pc    = pc_mem_q[rd_ptr_q];
    assign pop             = bus_io.if_valid && bus_io.if_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= push_instr;
            pc_mem_q[wr_ptr_q]    <= push_pc;
        end
    end

    // Reset drops any outstanding request, so a late rvalid lands in IDLE and is ignored.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= StIdle;
            tag_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pc_advance) begin
                        state_q <= StWait;
                        tag_q   <= pc_address;
                    end
                end
                StWait: begin
                    if (flush) begin
                        state_q <= bus_io.imem_rvalid ? StIdle : StDiscard;
                    end else if (pc_advance) begin
                        tag_q <= pc_address;
                    end else if (bus_io.imem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                StDiscard: begin
                    if (bus_io.imem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
